// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register with stall/flush handling and madd/msub accumulator hold.
// Optional bubble performance counter enabled by defining EX_MEM_PERF_EN.
module ex_mem_reg (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic        flush,
  input  logic [4:0]  ex_wd,
  input  logic        ex_wreg,
  input  logic [31:0] ex_wdata,
  input  logic        ex_whilo,
  input  logic [31:0] ex_hi,
  input  logic [31:0] ex_lo,
  input  logic [63:0] hilo_i,
  input  logic [1:0]  cnt_i,
  output logic [4:0]  mem_wd,
  output logic        mem_wreg,
  output logic [31:0] mem_wdata,
  output logic        mem_whilo,
  output logic [31:0] mem_hi,
  output logic [31:0] mem_lo,
  output logic        mem_valid,
  output logic [63:0] hilo_o,
  output logic [1:0]  cnt_o,
  output logic [31:0] bubble_cnt
);

  typedef enum logic [1:0] {
    ACT_ADVANCE,
    ACT_BUBBLE,
    ACT_HOLD,
    ACT_FLUSH
  } action_e;

  action_e action;

  logic unused_stall_bits;
  assign unused_stall_bits = ^{stall[5], stall[2:0]};

  // stall[4] without stall[3] is not a legal request and falls through to advance
  always_comb begin
    action = ACT_ADVANCE;
    if (flush)
      action = ACT_FLUSH;
    else if (stall[3] && stall[4])
      action = ACT_HOLD;
    else if (stall[3])
      action = ACT_BUBBLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_wd    <= '0;
      mem_wreg  <= 1'b0;
      mem_wdata <= '0;
      mem_whilo <= 1'b0;
      mem_hi    <= '0;
      mem_lo    <= '0;
      mem_valid <= 1'b0;
      hilo_o    <= '0;
      cnt_o     <= '0;
    end else begin
      unique case (action)
        ACT_FLUSH: begin
          mem_wd    <= '0;
          mem_wreg  <= 1'b0;
          mem_wdata <= '0;
          mem_whilo <= 1'b0;
          mem_hi    <= '0;
          mem_lo    <= '0;
          mem_valid <= 1'b0;
          hilo_o    <= '0;
          cnt_o     <= '0;
        end
        ACT_BUBBLE: begin
          mem_wd    <= '0;
          mem_wreg  <= 1'b0;
          mem_wdata <= '0;
          mem_whilo <= 1'b0;
          mem_hi    <= '0;
          mem_lo    <= '0;
          mem_valid <= 1'b0;
          hilo_o    <= hilo_i;
          cnt_o     <= cnt_i;
        end
        ACT_HOLD: begin
        end
        ACT_ADVANCE: begin
          mem_wd    <= ex_wd;
          mem_wreg  <= ex_wreg;
          mem_wdata <= ex_wdata;
          mem_whilo <= ex_whilo;
          mem_hi    <= ex_hi;
          mem_lo    <= ex_lo;
          mem_valid <= 1'b1;
          hilo_o    <= '0;
          cnt_o     <= '0;
        end
      endcase
    end
  end

`ifdef EX_MEM_PERF_EN
  logic [31:0] bubble_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      bubble_q <= '0;
    else if (action == ACT_BUBBLE)
      bubble_q <= bubble_q + 32'd1;
  end

  assign bubble_cnt = bubble_q;
`else
  assign bubble_cnt = '0;
`endif

endmodule
